// File: rtl/offset_encoder_if.sv
// Request/result bundle for offset_encoder: offset request in, packed immediate field and flags out.
// Handshake: a beat transfers on the rising edge where valid & ready are both high; valid must not depend on ready.
interface offset_encoder_if #(
    parameter int DATA_W = 64,
    parameter int LDST_W = 16,
    parameter int BEQ_W  = 21
);
    logic              in_valid;
    logic              in_ready;
    logic              in_kind;
    logic [DATA_W-1:0] in_value;
    logic              out_valid;
    logic              out_ready;
    logic              out_kind;
    logic [LDST_W-1:0] out_ldst;
    logic [BEQ_W-1:0]  out_beq;
    logic              out_range_err;
    logic              out_align_err;

    modport master (
        output in_valid, in_kind, in_value, out_ready,
        input  in_ready, out_valid, out_kind, out_ldst, out_beq, out_range_err, out_align_err
    );

    modport slave (
        input  in_valid, in_kind, in_value, out_ready,
        output in_ready, out_valid, out_kind, out_ldst, out_beq, out_range_err, out_align_err
    );
endinterface

// File: rtl/offset_encoder.sv
// Packs a signed 64-bit byte offset into a ldst (16-bit) or branch (21-bit, word-scaled) immediate.
// Two-stage valid/ready pipeline; define OFFSET_ENC_STATS_EN to add saturating pop/error counters.
module offset_encoder #(
    parameter int DATA_W    = 64,
    parameter int LDST_W    = 16,
    parameter int BEQ_W     = 21,
    parameter int BEQ_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    offset_encoder_if.slave   bus
`ifdef OFFSET_ENC_STATS_EN
    ,
    output logic [15:0]       stat_cnt,
    output logic [15:0]       stat_rng_cnt,
    output logic [15:0]       stat_aln_cnt
`endif
);
    localparam int BEQ_HI = BEQ_W + BEQ_SHIFT;

    logic              s1_valid_q, s1_valid_d;
    logic              s1_kind_q, s1_kind_d;
    logic [DATA_W-1:0] s1_value_q, s1_value_d;

    logic              out_valid_q, out_valid_d;
    logic              out_kind_q, out_kind_d;
    logic [LDST_W-1:0] out_ldst_q, out_ldst_d;
    logic [BEQ_W-1:0]  out_beq_q, out_beq_d;
    logic              out_rng_q, out_rng_d;
    logic              out_aln_q, out_aln_d;

    logic              s2_free;
    logic              in_ready;
    logic              accept;
    logic [LDST_W-1:0] ldst_field;
    logic              ldst_rng;
    logic [BEQ_W-1:0]  beq_field;
    logic              beq_rng;
    logic              beq_aln;

    always_comb begin
        s2_free  = !out_valid_q || bus.out_ready;
        in_ready = !s1_valid_q || s2_free;
        accept   = bus.in_valid && in_ready;
    end

    // Encodable iff every bit from the field's sign bit upward matches, i.e. sign-extension round-trips.
    always_comb begin
        ldst_field = s1_value_q[LDST_W-1:0];
        ldst_rng   = !((&s1_value_q[DATA_W-1:LDST_W-1]) || !(|s1_value_q[DATA_W-1:LDST_W-1]));
        beq_field  = s1_value_q[BEQ_HI-1:BEQ_SHIFT];
        beq_rng    = !((&s1_value_q[DATA_W-1:BEQ_HI-1]) || !(|s1_value_q[DATA_W-1:BEQ_HI-1]));
        beq_aln    = |s1_value_q[BEQ_SHIFT-1:0];
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_kind_d  = s1_kind_q;
        s1_value_d = s1_value_q;
        if (in_ready) begin
            s1_valid_d = bus.in_valid;
        end
        if (accept) begin
            s1_kind_d  = bus.in_kind;
            s1_value_d = bus.in_value;
        end
    end

    // Stage 2 only moves when its slot is free, so a stalled result stays frozen on the outputs.
    always_comb begin
        out_valid_d = out_valid_q;
        out_kind_d  = out_kind_q;
        out_ldst_d  = out_ldst_q;
        out_beq_d   = out_beq_q;
        out_rng_d   = out_rng_q;
        out_aln_d   = out_aln_q;
        if (s2_free) begin
            out_valid_d = s1_valid_q;
            out_kind_d  = s1_valid_q && s1_kind_q;
            out_ldst_d  = (s1_valid_q && !s1_kind_q) ? ldst_field : '0;
            out_beq_d   = (s1_valid_q && s1_kind_q) ? beq_field : '0;
            out_rng_d   = s1_valid_q && (s1_kind_q ? beq_rng : ldst_rng);
            out_aln_d   = s1_valid_q && s1_kind_q && beq_aln;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_kind_q   <= 1'b0;
            s1_value_q  <= '0;
            out_valid_q <= 1'b0;
            out_kind_q  <= 1'b0;
            out_ldst_q  <= '0;
            out_beq_q   <= '0;
            out_rng_q   <= 1'b0;
            out_aln_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_kind_q   <= s1_kind_d;
            s1_value_q  <= s1_value_d;
            out_valid_q <= out_valid_d;
            out_kind_q  <= out_kind_d;
            out_ldst_q  <= out_ldst_d;
            out_beq_q   <= out_beq_d;
            out_rng_q   <= out_rng_d;
            out_aln_q   <= out_aln_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_kind      = out_kind_q;
    assign bus.out_ldst      = out_ldst_q;
    assign bus.out_beq       = out_beq_q;
    assign bus.out_range_err = out_rng_q;
    assign bus.out_align_err = out_aln_q;

`ifdef OFFSET_ENC_STATS_EN
    logic        pop;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] rng_cnt_q, rng_cnt_d;
    logic [15:0] aln_cnt_q, aln_cnt_d;

    // Counters saturate rather than wrap so a long run never reads as a small count.
    always_comb begin
        pop       = out_valid_q && bus.out_ready;
        cnt_d     = cnt_q;
        rng_cnt_d = rng_cnt_q;
        aln_cnt_d = aln_cnt_q;
        if (pop && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
        if (pop && out_rng_q && rng_cnt_q != 16'hFFFF) begin
            rng_cnt_d = rng_cnt_q + 16'd1;
        end
        if (pop && out_aln_q && aln_cnt_q != 16'hFFFF) begin
            aln_cnt_d = aln_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            rng_cnt_q <= '0;
            aln_cnt_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            rng_cnt_q <= rng_cnt_d;
            aln_cnt_q <= aln_cnt_d;
        end
    end

    assign stat_cnt     = cnt_q;
    assign stat_rng_cnt = rng_cnt_q;
    assign stat_aln_cnt = aln_cnt_q;
`endif
endmodule

// File: tb/tb_offset_encoder.sv
// Self-checking bench for offset_encoder: directed boundary vectors, back-to-back, stall, reset and
// randomized traffic against an arithmetic reference model (plus counter checks with OFFSET_ENC_STATS_EN).
module tb_offset_encoder;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    offset_encoder_if bus ();

`ifdef OFFSET_ENC_STATS_EN
    logic [15:0] stat_cnt, stat_rng_cnt, stat_aln_cnt;
    int          m_cnt, m_rng, m_aln;
`endif

    offset_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef OFFSET_ENC_STATS_EN
        ,
        .stat_cnt     (stat_cnt),
        .stat_rng_cnt (stat_rng_cnt),
        .stat_aln_cnt (stat_aln_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Result word: {kind, ldst[15:0], beq[20:0], range_err, align_err}
    function automatic logic [39:0] model(input logic kind, input logic [63:0] value);
        longint     sv;
        logic [15:0] ldst;
        logic [20:0] beq;
        logic        rng, aln;
        sv   = signed'(value);
        ldst = '0;
        beq  = '0;
        aln  = 1'b0;
        if (!kind) begin
            ldst = value[15:0];
            rng  = (sv < -32768) || (sv > 32767);
        end else begin
            beq = 21'(sv >>> 2);
            rng = (sv < -4194304) || (sv > 4194303);
            aln = (sv & 64'sd3) != 0;
        end
        return {kind, ldst, beq, rng, aln};
    endfunction

    function automatic logic [39:0] pack_out();
        return {bus.out_kind, bus.out_ldst, bus.out_beq, bus.out_range_err, bus.out_align_err};
    endfunction

    function automatic logic [63:0] rand_value();
        longint r;
        case ($urandom_range(0, 5))
            0: r = longint'($urandom_range(0, 65535)) - 32768;
            1: r = ($urandom_range(0, 1) ? 64'sd32767 : -64'sd32768) + longint'($urandom_range(0, 2)) - 1;
            2: r = ($urandom_range(0, 1) ? 64'sd4194303 : -64'sd4194304) + longint'($urandom_range(0, 8)) - 4;
            3: r = longint'($urandom_range(0, 1 << 24)) - (1 << 23);
            4: r = {$urandom, $urandom};
            default: r = longint'($urandom_range(0, 255)) - 128;
        endcase
        return 64'(r);
    endfunction

    // ---------------- scoreboard ----------------
    logic [39:0] exp_q[$];
    logic        prev_stall;
    logic [39:0] prev_out;

    always @(negedge clk) begin
        logic [39:0] cur;
        logic [39:0] exp;
        if (rst_n) begin
            cur = pack_out();
            if (prev_stall) begin
                check_eq("stall_hold", 64'(cur), 64'(prev_out));
                check_eq("stall_valid", 64'(bus.out_valid), 64'd1);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = cur;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_pop", 64'd1, 64'd0);
                end else begin
                    exp = exp_q.pop_front();
                    check_eq("result", 64'(cur), 64'(exp));
`ifdef OFFSET_ENC_STATS_EN
                    if (m_cnt < 65535) m_cnt++;
                    if (exp[1] && m_rng < 65535) m_rng++;
                    if (exp[0] && m_aln < 65535) m_aln++;
`endif
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.in_kind, bus.in_value));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic drive_req(input logic kind, input logic [63:0] value);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_kind  = kind;
        bus.in_value = value;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            done = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) check_eq("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int w;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Request presented in cycle c is visible on the outputs in cycle c+2.
    task automatic single(input logic kind, input logic [63:0] value, input logic [20:0] field,
                          input logic rng, input logic aln);
        bus.out_ready = 1'b1;
        drive_req(kind, value);
        bus.in_valid = 1'b0;
        check_eq("lat_early", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        check_eq("lat_valid", 64'(bus.out_valid), 64'd1);
        check_eq("dir_field", kind ? 64'(bus.out_beq) : 64'(bus.out_ldst), 64'(field));
        check_eq("dir_rng", 64'(bus.out_range_err), 64'(rng));
        check_eq("dir_aln", 64'(bus.out_align_err), 64'(aln));
        @(posedge clk);
        #1;
    endtask

    task automatic random_phase(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.in_kind   = $urandom_range(0, 1);
            bus.in_value  = rand_value();
            @(posedge clk);
            #1;
        end
        drain();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        prev_stall = 1'b0;
`ifdef OFFSET_ENC_STATS_EN
        m_cnt = 0;
        m_rng = 0;
        m_aln = 0;
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int acc;
        int w;
        n_cmp = 0;
        n_err = 0;
        prev_stall = 1'b0;
        prev_out   = '0;
        bus.in_valid  = 1'b0;
        bus.in_kind   = 1'b0;
        bus.in_value  = '0;
        bus.out_ready = 1'b1;
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_ready", 64'(bus.in_ready), 64'd1);
        check_eq("rst_outs", 64'(pack_out()), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        single(1'b0, 64'h0000_0000_0000_7FFF, 21'h7FFF, 1'b0, 1'b0);
        single(1'b0, 64'hFFFF_FFFF_FFFF_8000, 21'h8000, 1'b0, 1'b0);
        single(1'b0, 64'h0000_0000_0000_8000, 21'h8000, 1'b1, 1'b0);
        single(1'b0, 64'hFFFF_FFFF_FFFF_7FFF, 21'h7FFF, 1'b1, 1'b0);
        single(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 21'h1FFFFF, 1'b0, 1'b0);
        single(1'b1, 64'd4194300, 21'h0FFFFF, 1'b0, 1'b0);
        single(1'b1, 64'd4194304, 21'h100000, 1'b1, 1'b0);
        single(1'b1, 64'd6, 21'h1, 1'b0, 1'b1);
        single(1'b1, 64'hFFFF_FFFF_FFC0_0000, 21'h100000, 1'b0, 1'b0);

        // Back-to-back: eight results on consecutive cycles
        bus.out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) drive_req($urandom_range(0, 1), rand_value());
                bus.in_valid = 1'b0;
            end
            begin
                int wv;
                wv = 0;
                @(negedge clk);
                while (!bus.out_valid && wv < 10) begin
                    @(negedge clk);
                    wv++;
                end
                for (int i = 0; i < 8; i++) begin
                    check_eq("b2b_valid", 64'(bus.out_valid), 64'd1);
                    @(negedge clk);
                end
            end
        join
        @(posedge clk);
        #1;
        drain();

        // Stall: only two requests fit while the consumer is blocked
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_kind   = $urandom_range(0, 1);
        bus.in_value  = rand_value();
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            bit took;
            @(negedge clk);
            took = bus.in_ready;
            @(posedge clk);
            #1;
            if (took) begin
                acc++;
                bus.in_kind  = $urandom_range(0, 1);
                bus.in_value = rand_value();
            end
        end
        check_eq("stall_accepts", 64'(acc), 64'd2);
        check_eq("stall_in_ready", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        w = 0;
        while (acc < 3 && w < 20) begin
            bit took;
            @(negedge clk);
            took = bus.in_ready;
            @(posedge clk);
            #1;
            if (took) acc++;
            w++;
        end
        check_eq("stall_third", 64'(acc), 64'd3);
        drain();

        random_phase(300);

        // Reset mid-stream with a blocked, full pipeline
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) drive_req($urandom_range(0, 1), rand_value());
        bus.in_valid = 1'b1;
        check_eq("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        do_reset();
        check_eq("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check_eq("mid_rst_ready", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        random_phase(200);

`ifdef OFFSET_ENC_STATS_EN
        check_eq("stat_cnt", 64'(stat_cnt), 64'(m_cnt));
        check_eq("stat_rng", 64'(stat_rng_cnt), 64'(m_rng));
        check_eq("stat_aln", 64'(stat_aln_cnt), 64'(m_aln));
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_kind   = 1'b1;
        bus.in_value  = 64'd6;
        repeat (70000) @(posedge clk);
        #1;
        drain();
        check_eq("stat_cnt_sat", 64'(stat_cnt), 64'hFFFF);
        check_eq("stat_aln_sat", 64'(stat_aln_cnt), 64'hFFFF);
        check_eq("stat_rng_model", 64'(stat_rng_cnt), 64'(m_rng));
        do_reset();
        check_eq("stat_cnt_rst", 64'(stat_cnt), 64'd0);
        check_eq("stat_rng_rst", 64'(stat_rng_cnt), 64'd0);
        check_eq("stat_aln_rst", 64'(stat_aln_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
